// File: rtl/exec_trace_buffer.sv
// Execution trace buffer: captures one entry per new datapath PC into a
// first-word-fall-through FIFO and stops capture once the PC stalls.
module exec_trace_buffer #(
   parameter int DEPTH       = 16,
   parameter int PC_W        = 8,
   parameter int OP_W        = 6,
   parameter int DATA_W      = 32,
   parameter int HALT_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [PC_W-1:0]          pc_in,
   input  logic [OP_W-1:0]          opcode_in,
   input  logic [DATA_W-1:0]        result_in,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output logic [PC_W-1:0]          trc_pc,
   output logic [OP_W-1:0]          trc_opcode,
   output logic [DATA_W-1:0]        trc_result,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(HALT_CYCLES + 1);
   localparam int EW = PC_W + OP_W + DATA_W;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HALTED
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;
   logic              ovf;
   logic              first;
   logic [PC_W-1:0]   last_pc;
   logic [SW-1:0]     stall;
   logic [SW-1:0]     stall_nxt;
   logic              armed;
   logic              full;
   logic              pop;
   logic              push_req;
   logic              push;
   logic              halt_hit;

   // A start cycle is a flush cycle: it neither captures nor counts stall.
   always_comb begin
      armed     = (state == ARMED) && !start;
      stall_nxt = '0;
      if (armed && !first && (pc_in == last_pc)) begin
         if (stall == SW'(HALT_CYCLES))
            stall_nxt = stall;
         else
            stall_nxt = stall + 1'b1;
      end
      halt_hit = armed && (stall_nxt == SW'(HALT_CYCLES));
      push_req = armed && (first || (pc_in != last_pc));
      full     = (cnt == CW'(DEPTH));
      pop      = (cnt != '0) && trc_ready;
      push     = push_req && (!full || pop);
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ARMED;
      end else begin
         unique case (state)
            IDLE:    state_nxt = IDLE;
            ARMED:   if (halt_hit) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         first   <= 1'b0;
         last_pc <= '0;
         stall   <= '0;
      end else if (start) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         first   <= 1'b1;
         stall   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt   <= cnt + CW'(push) - CW'(pop);
         stall <= stall_nxt;
         if (push_req && full && !pop) ovf <= 1'b1;
         if (state == ARMED) begin
            first   <= 1'b0;
            last_pc <= pc_in;
         end
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {pc_in, opcode_in, result_in};
   end

   assign trc_valid = (cnt != '0);
   assign {trc_pc, trc_opcode, trc_result} = trc_valid ? mem[rd_ptr] : '0;
   assign count    = cnt;
   assign overflow = ovf;
   assign halted   = (state == HALTED);

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboard bench for exec_trace_buffer: directed traces with expected
// entries queued at stimulus time and checked by a handshake monitor.
module tb_exec_trace_buffer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  pc_in;
   logic [5:0]  opcode_in;
   logic [31:0] result_in;
   logic        trc_valid;
   logic        trc_ready;
   logic [7:0]  trc_pc;
   logic [5:0]  trc_opcode;
   logic [31:0] trc_result;
   logic [4:0]  count;
   logic        overflow;
   logic        halted;

   typedef struct {
      logic [7:0]  pc;
      logic [5:0]  op;
      logic [31:0] res;
   } ent_t;

   ent_t        q[$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] last_res = '0;

   exec_trace_buffer #(
      .DEPTH(16), .PC_W(8), .OP_W(6), .DATA_W(32), .HALT_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pc_in(pc_in), .opcode_in(opcode_in), .result_in(result_in),
      .trc_valid(trc_valid), .trc_ready(trc_ready),
      .trc_pc(trc_pc), .trc_opcode(trc_opcode), .trc_result(trc_result),
      .count(count), .overflow(overflow), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every accepted head entry must match the scoreboard front.
   always @(negedge clk) begin
      if (rst_n && trc_valid && trc_ready) begin
         total++;
         if (q.size() == 0) begin
            $display("FAIL pop_unexpected: got pc %0h expected none", trc_pc);
         end else begin
            ent_t e;
            e = q.pop_front();
            if (trc_pc === e.pc && trc_opcode === e.op && trc_result === e.res)
               passed++;
            else
               $display("FAIL pop_entry: got %0h/%0h/%0h expected %0h/%0h/%0h",
                        trc_pc, trc_opcode, trc_result, e.pc, e.op, e.res);
         end
         last_res = trc_result;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one datapath cycle; exp_push is the hand-derived capture decision.
   task automatic drive(input logic [7:0] pc, input logic [5:0] op,
                        input logic [31:0] res, input bit exp_push);
      pc_in     = pc;
      opcode_in = op;
      result_in = res;
      if (exp_push) q.push_back('{pc, op, res});
      step();
   endtask

   task automatic arm();
      trc_ready = 1'b0;
      start     = 1'b1;
      q.delete();
      step();
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      trc_ready = 1'b1;
      while (trc_valid && n < 40) begin
         step();
         n++;
      end
      trc_ready = 1'b0;
      chk({name, "_timeout"}, 32'(n < 40), 32'd1);
      chk({name, "_count"}, 32'(count), 32'd0);
      chk({name, "_sb_empty"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; trc_ready = 1'b0;
      pc_in = '0; opcode_in = '0; result_in = '0;
      repeat (2) step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(trc_valid), 32'd0);
      chk("rst_pc", 32'(trc_pc), 32'd0);
      chk("rst_result", trc_result, 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: four distinct PCs captured, head stays at pc 0
      arm();
      drive(8'd0, 6'b001000, 32'd0, 1'b1);
      chk("t1_valid_first", 32'(trc_valid), 32'd1);
      chk("t1_head_first", 32'(trc_pc), 32'd0);
      for (int i = 1; i < 4; i++) drive(8'(i), 6'b000000, 32'(i * 10), 1'b1);
      chk("t1_count", 32'(count), 32'd4);
      chk("t1_head_pc", 32'(trc_pc), 32'd0);
      chk("t1_head_op", 32'(trc_opcode), 32'b001000);

      // 2: halt after four stalled cycles at pc 5
      drive(8'd4, 6'd0, 32'd40, 1'b1);
      drive(8'd5, 6'd0, 32'd50, 1'b1);
      for (int i = 0; i < 3; i++) drive(8'd5, 6'd0, 32'd50, 1'b0);
      chk("t2_not_halted_3", 32'(halted), 32'd0);
      drive(8'd5, 6'd0, 32'd50, 1'b0);
      chk("t2_halted", 32'(halted), 32'd1);
      drive(8'd6, 6'd0, 32'd60, 1'b0);
      drive(8'd7, 6'd0, 32'd70, 1'b0);
      chk("t2_count", 32'(count), 32'd6);
      drain("t2_drain");

      // 3: overflow drops pcs 16 and 17
      arm();
      for (int i = 0; i < 18; i++) drive(8'(i), 6'd2, 32'(i + 100), i < 16);
      chk("t3_count", 32'(count), 32'd16);
      chk("t3_overflow", 32'(overflow), 32'd1);
      drain("t3_drain");
      chk("t3_overflow_sticky", 32'(overflow), 32'd1);

      // 4: full FIFO with simultaneous push and pop
      arm();
      chk("t4_overflow_clr", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) drive(8'(i), 6'd3, 32'(i), 1'b1);
      chk("t4_full", 32'(count), 32'd16);
      trc_ready = 1'b1;
      drive(8'd16, 6'd3, 32'd16, 1'b1);
      trc_ready = 1'b0;
      chk("t4_count", 32'(count), 32'd16);
      chk("t4_overflow", 32'(overflow), 32'd0);
      chk("t4_head", 32'(trc_pc), 32'd1);
      drain("t4_drain");

      // 5: factorial loop, acc=5*4*3*2*1, drained live
      arm();
      trc_ready = 1'b1;
      drive(8'd0, 6'd8, 32'd1, 1'b1);
      drive(8'd1, 6'd8, 32'd5, 1'b1);
      drive(8'd2, 6'd9, 32'd5, 1'b1);
      drive(8'd3, 6'd4, 32'd4, 1'b1);
      drive(8'd2, 6'd9, 32'd20, 1'b1);
      drive(8'd3, 6'd4, 32'd3, 1'b1);
      drive(8'd2, 6'd9, 32'd60, 1'b1);
      drive(8'd3, 6'd4, 32'd2, 1'b1);
      drive(8'd2, 6'd9, 32'd120, 1'b1);
      drive(8'd3, 6'd4, 32'd1, 1'b1);
      drive(8'd4, 6'd5, 32'd120, 1'b1);
      for (int i = 0; i < 6; i++) drive(8'd4, 6'd5, 32'd120, 1'b0);
      chk("t5_halted", 32'(halted), 32'd1);
      chk("t5_last_result", last_res, 32'd120);
      chk("t5_sb_empty", 32'(q.size()), 32'd0);
      trc_ready = 1'b0;

      // 6: asynchronous reset mid-capture, then re-arm
      arm();
      for (int i = 0; i < 7; i++) drive(8'(i + 32), 6'd1, 32'(i), 1'b1);
      chk("t6_count_pre", 32'(count), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_count", 32'(count), 32'd0);
      chk("t6_rst_valid", 32'(trc_valid), 32'd0);
      q.delete();
      step();
      rst_n = 1'b1;
      drive(8'h33, 6'd1, 32'd9, 1'b0);
      chk("t6_idle_count", 32'(count), 32'd0);
      arm();
      drive(8'h40, 6'd1, 32'd1, 1'b1);
      drive(8'h41, 6'd1, 32'd2, 1'b1);
      chk("t6_rearm_count", 32'(count), 32'd2);
      chk("t6_rearm_head", 32'(trc_pc), 32'h40);
      drain("t6_drain");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
